// File: rtl/random_delay.sv
// random_delay: waits a random number of milliseconds after a start request.
//
// The delay is MIN_MS plus the 12-bit value offered by an upstream LFSR,
// captured the cycle the FSM enters COUNT. A 16-bit tick counter divides
// clk down to 1 ms ticks, and ms_left counts down once per tick for display.
//
// Build option: define RANDOM_DELAY_STICKY_DONE_EN to keep done asserted in
// DONE until start or abort is seen. Without it, done is a one-cycle pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// WAIT_RDY | start seen, waiting for lfsr_ready before capturing
// COUNT    | delay captured, ms_left counting down on each 1 ms tick
// DONE     | delay expired, done asserted

module random_delay #(
    parameter int TICK_DIV = 50000,
    parameter int MIN_MS   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] lfsr_val,
    input  logic        lfsr_ready,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [12:0] delay_ms,
    output logic [12:0] ms_left
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        COUNT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [12:0] MIN_MS_W  = 13'(MIN_MS);

    state_t      state;
    state_t      next_state;
    logic [15:0] tick_cnt;
    logic        capture;
    logic        tick_last;
    logic [12:0] new_delay;

    // Both operands fit in 12 bits, so the 13-bit sum cannot overflow.
    assign new_delay = MIN_MS_W + {1'b0, lfsr_val};
    assign tick_last = (tick_cnt == TICK_LAST);

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the capture strobe for entry into COUNT.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lfsr_ready) begin
                            next_state = COUNT;
                            capture    = 1'b1;
                        end else begin
                            next_state = WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (lfsr_ready) begin
                        next_state = COUNT;
                        capture    = 1'b1;
                    end
                end
                COUNT: begin
                    // A zero delay finishes on the cycle after capture.
                    if (ms_left == 13'd0) begin
                        next_state = DONE;
                    end else if (tick_last && (ms_left == 13'd1)) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
`ifdef RANDOM_DELAY_STICKY_DONE_EN
                    // A start here is treated exactly like a start in IDLE.
                    if (start) begin
                        if (lfsr_ready) begin
                            next_state = COUNT;
                            capture    = 1'b1;
                        end else begin
                            next_state = WAIT_RDY;
                        end
                    end
`else
                    next_state = IDLE;
`endif
                end
                default: next_state = IDLE;
            endcase
        end

        busy = (state == WAIT_RDY) || (state == COUNT);
        done = (state == DONE);
    end

    // Delay capture, 1 ms tick divider and ms_left countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_ms <= 13'd0;
            ms_left  <= 13'd0;
            tick_cnt <= 16'd0;
        end else if (abort) begin
            // delay_ms is kept so the last captured value stays visible.
            ms_left  <= 13'd0;
            tick_cnt <= 16'd0;
        end else if (capture) begin
            delay_ms <= new_delay;
            ms_left  <= new_delay;
            tick_cnt <= 16'd0;
        end else if ((state == COUNT) && (ms_left != 13'd0)) begin
            if (tick_last) begin
                tick_cnt <= 16'd0;
                ms_left  <= ms_left - 13'd1;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end else begin
            tick_cnt <= 16'd0;
        end
    end

endmodule

// File: tb/tb_random_delay.sv
// tb_random_delay: directed checks of random_delay with TICK_DIV=4.
// Instance dut uses MIN_MS=2; instance dut_z uses MIN_MS=0 for the
// zero-delay case. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, away from the active edge.

module tb_random_delay;

`ifdef RANDOM_DELAY_STICKY_DONE_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] lfsr_val = 12'd0;
    logic        lfsr_ready = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        start_z = 1'b0;
    logic        abort_z = 1'b0;

    logic        busy, done, busy_z, done_z;
    logic [12:0] delay_ms, ms_left, delay_ms_z, ms_left_z;

    int n_vec = 0;
    int n_err = 0;

    random_delay #(.TICK_DIV(4), .MIN_MS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .lfsr_val   (lfsr_val),
        .lfsr_ready (lfsr_ready),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .delay_ms   (delay_ms),
        .ms_left    (ms_left)
    );

    random_delay #(.TICK_DIV(4), .MIN_MS(0)) dut_z (
        .clk        (clk),
        .reset      (reset),
        .lfsr_val   (lfsr_val),
        .lfsr_ready (lfsr_ready),
        .start      (start_z),
        .abort      (abort_z),
        .busy       (busy_z),
        .done       (done_z),
        .delay_ms   (delay_ms_z),
        .ms_left    (ms_left_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_abort();
        abort   = 1'b1;
        abort_z = 1'b1;
        step();
        abort   = 1'b0;
        abort_z = 1'b0;
    endtask

    initial begin
        int  busy_cyc;
        int  cnt;
        bit  bad;

        // Reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_delay", delay_ms, 0);
        chk("rst_left", ms_left, 0);
        reset = 1'b0;
        step();

        // Ready LFSR, value 3 -> 5 ms = 20 cycles
        lfsr_ready = 1'b1;
        lfsr_val   = 12'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("t1_delay", delay_ms, 5);
        chk("t1_left0", ms_left, 5);
        busy_cyc = busy ? 1 : 0;
        bad = 1'b0;
        for (int k = 1; k < 20; k++) begin
            step();
            if (busy) busy_cyc++;
            if (done) bad = 1'b1;
            case (k)
                4:  chk("t1_left4", ms_left, 4);
                8:  chk("t1_left3", ms_left, 3);
                12: chk("t1_left2", ms_left, 2);
                16: chk("t1_left1", ms_left, 1);
                default: ;
            endcase
        end
        chk("t1_early_done", bad, 0);
        step();
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_left_end", ms_left, 0);
        chk("t1_busy_cycles", busy_cyc, 20);
        step();
        chk("t1_done_after", done, STICKY ? 1 : 0);
        chk("t1_delay_held", delay_ms, 5);
        pulse_abort();

        // LFSR not ready at start; ready raised after 7 cycles with value 0
        lfsr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_wait_busy", busy, 1);
        bad = 1'b0;
        for (int k = 1; k < 7; k++) begin
            step();
            if (!busy || delay_ms != 13'd5 || ms_left != 13'd0) bad = 1'b1;
        end
        chk("t2_wait_hold", bad, 0);
        lfsr_val   = 12'd0;
        lfsr_ready = 1'b1;
        step();
        lfsr_ready = 1'b0;
        chk("t2_delay", delay_ms, 2);
        chk("t2_left", ms_left, 2);
        bad = 1'b0;
        for (int k = 1; k < 8; k++) begin
            step();
            if (done) bad = 1'b1;
            if (k == 4) chk("t2_left_mid", ms_left, 1);
        end
        chk("t2_early_done", bad, 0);
        step();
        chk("t2_done", done, 1);
        pulse_abort();

        // Abort on cycle 10 of COUNT
        lfsr_ready = 1'b1;
        lfsr_val   = 12'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        chk("t3_left_pre", ms_left, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_busy", busy, 0);
        chk("t3_left", ms_left, 0);
        chk("t3_delay_held", delay_ms, 5);
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done || busy) bad = 1'b1;
        end
        chk("t3_no_done", bad, 0);

        // Start and abort together in IDLE
        lfsr_val = 12'd7;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t3b_busy", busy, 0);
        chk("t3b_delay", delay_ms, 5);

        // Second start during COUNT is ignored
        lfsr_val = 12'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_delay", delay_ms, 3);
        step();
        step();
        lfsr_val = 12'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_delay_kept", delay_ms, 3);
        chk("t4_left_kept", ms_left, 3);
        cnt = 3;
        while (!done && cnt < 40) begin
            step();
            cnt++;
        end
        chk("t4_latency", cnt, 12);
        pulse_abort();

        // MIN_MS=0 with value 0: done on the second edge after start
        lfsr_val = 12'd0;
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        chk("t5_busy", busy_z, 1);
        chk("t5_delay", delay_ms_z, 0);
        chk("t5_done_early", done_z, 0);
        step();
        chk("t5_done", done_z, 1);
        step();
        chk("t5_done_after", done_z, STICKY ? 1 : 0);
        pulse_abort();

        // Reset mid-COUNT between edges
        lfsr_val = 12'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        #3;
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_delay", delay_ms, 0);
        chk("t6_left", ms_left, 0);
        step();
        step();
        #2;
        reset = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (busy || done || ms_left != 13'd0) bad = 1'b1;
        end
        chk("t6_idle_after", bad, 0);

`ifdef RANDOM_DELAY_STICKY_DONE_EN
        // Sticky done held until start, which recaptures on the same edge
        lfsr_val = 12'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("t7_done", done, 1);
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (!done || busy) bad = 1'b1;
        end
        chk("t7_done_held", bad, 0);
        lfsr_val = 12'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t7_done_drop", done, 0);
        chk("t7_delay", delay_ms, 7);
        chk("t7_busy", busy, 1);
        pulse_abort();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
